// File: rtl/nasti_stream_mux_if.sv
`default_nettype none
// ============================================================================
// Module   : nasti_stream_channel
// Purpose  : Bundle of N_CHAN parallel NASTI stream lanes (data, sideband, handshake).
// Revision : 1.0
// ============================================================================
interface nasti_stream_channel #(
    parameter int N_CHAN     = 1,
    parameter int DATA_WIDTH = 8,
    parameter int ID_WIDTH   = 1,
    parameter int DEST_WIDTH = 1,
    parameter int USER_WIDTH = 1
) ();
    localparam int STRB_WIDTH = (DATA_WIDTH + 7) / 8;

    logic [N_CHAN-1:0][DATA_WIDTH-1:0] t_data;
    logic [N_CHAN-1:0][STRB_WIDTH-1:0] t_strb;
    logic [N_CHAN-1:0][STRB_WIDTH-1:0] t_keep;
    logic [N_CHAN-1:0]                 t_last;
    logic [N_CHAN-1:0][ID_WIDTH-1:0]   t_id;
    logic [N_CHAN-1:0][DEST_WIDTH-1:0] t_dest;
    logic [N_CHAN-1:0][USER_WIDTH-1:0] t_user;
    logic [N_CHAN-1:0]                 t_valid;
    logic [N_CHAN-1:0]                 t_ready;

    modport master (
        output t_data, t_strb, t_keep, t_last, t_id, t_dest, t_user, t_valid,
        input  t_ready
    );

    modport slave (
        input  t_data, t_strb, t_keep, t_last, t_id, t_dest, t_user, t_valid,
        output t_ready
    );
endinterface
`default_nettype wire

// File: rtl/nasti_stream_mux.sv
`default_nettype none
// ============================================================================
// Module   : nasti_stream_mux
// Purpose  : Packet-granular round-robin N-to-1 NASTI stream multiplexer.
// Revision : 1.0
// ============================================================================
module nasti_stream_mux #(
    parameter int N_PORT       = 2,
    parameter int SELECT_WIDTH = (N_PORT > 1) ? $clog2(N_PORT) : 1
) (
    input  wire                         aclk,
    input  wire                         aresetn,
    nasti_stream_channel.slave          master,
    nasti_stream_channel.master         slave,
    input  wire                         enable,
    output logic                        busy,
    output logic [SELECT_WIDTH-1:0]     grant,
    output logic [15:0]                 pkt_count
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [SELECT_WIDTH-1:0] grant_q, grant_d;
    logic [SELECT_WIDTH-1:0] rr_ptr_q, rr_ptr_d;
    logic [15:0]             pkt_count_q, pkt_count_d;

    logic [2*N_PORT-1:0]     req_twice;
    logic [N_PORT-1:0]       req_rot;
    logic [SELECT_WIDTH:0]   cand;
    logic [SELECT_WIDTH:0]   ptr_next;
    logic [SELECT_WIDTH-1:0] pick;
    logic                    pick_valid;
    logic                    beat_fire;
    logic                    beat_last;

    // Requests rotated so bit k is lane (rr_ptr + k) mod N_PORT; lowest set bit wins.
    always_comb begin
        req_twice  = {master.t_valid, master.t_valid};
        req_rot    = req_twice[rr_ptr_q +: N_PORT];
        cand       = '0;
        pick       = '0;
        pick_valid = 1'b0;
        for (int k = N_PORT - 1; k >= 0; k--) begin
            if (req_rot[k]) begin
                cand = {1'b0, rr_ptr_q} + (SELECT_WIDTH + 1)'(k);
                if (cand >= (SELECT_WIDTH + 1)'(N_PORT)) begin
                    cand = cand - (SELECT_WIDTH + 1)'(N_PORT);
                end
                pick       = cand[SELECT_WIDTH-1:0];
                pick_valid = 1'b1;
            end
        end
    end

    always_comb begin
        ptr_next = {1'b0, grant_q} + (SELECT_WIDTH + 1)'(1);
        if (ptr_next >= (SELECT_WIDTH + 1)'(N_PORT)) begin
            ptr_next = '0;
        end
    end

    assign beat_fire = (state_q == ST_BUSY) && master.t_valid[grant_q] && slave.t_ready[0];
    assign beat_last = master.t_last[grant_q];

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        rr_ptr_d    = rr_ptr_q;
        pkt_count_d = pkt_count_q;
        case (state_q)
            ST_IDLE: begin
                if (enable && pick_valid) begin
                    state_d = ST_BUSY;
                    grant_d = pick;
                end
            end
            ST_BUSY: begin
                // The grant is held until the tail beat is accepted; enable is not consulted.
                if (beat_fire && beat_last) begin
                    state_d     = ST_IDLE;
                    grant_d     = '0;
                    rr_ptr_d    = ptr_next[SELECT_WIDTH-1:0];
                    pkt_count_d = pkt_count_q + 16'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q     <= ST_IDLE;
            grant_q     <= '0;
            rr_ptr_q    <= '0;
            pkt_count_q <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            rr_ptr_q    <= rr_ptr_d;
            pkt_count_q <= pkt_count_d;
        end
    end

    // Data path follows grant_q, which rests at 0 while idle.
    always_comb begin
        slave.t_data[0]  = master.t_data[grant_q];
        slave.t_strb[0]  = master.t_strb[grant_q];
        slave.t_keep[0]  = master.t_keep[grant_q];
        slave.t_last[0]  = master.t_last[grant_q];
        slave.t_id[0]    = master.t_id[grant_q];
        slave.t_dest[0]  = master.t_dest[grant_q];
        slave.t_user[0]  = master.t_user[grant_q];
        slave.t_valid[0] = (state_q == ST_BUSY) && master.t_valid[grant_q];
    end

    always_comb begin
        master.t_ready = '0;
        if (state_q == ST_BUSY) begin
            master.t_ready[grant_q] = slave.t_ready[0];
        end
    end

    assign busy      = (state_q == ST_BUSY);
    assign grant     = grant_q;
    assign pkt_count = pkt_count_q;

endmodule
`default_nettype wire

// File: tb/tb_nasti_stream_mux.sv
`default_nettype none
// Bench for nasti_stream_mux: randomized lane sources, packet-level round-robin
// reference model, and a scoreboard of per-lane expected beats.
module tb_nasti_stream_mux;
    localparam int N   = 4;
    localparam int DW  = 8;
    localparam int IW  = 2;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          strb;
        logic          keep;
        logic          last;
        logic [IW-1:0] id;
        logic          dest;
        logic          user;
    } beat_t;

    logic        aclk    = 1'b0;
    logic        aresetn = 1'b0;
    logic        enable  = 1'b0;
    logic        busy;
    logic [1:0]  grant;
    logic [15:0] pkt_count;

    nasti_stream_channel #(.N_CHAN(N), .DATA_WIDTH(DW), .ID_WIDTH(IW), .DEST_WIDTH(1), .USER_WIDTH(1)) up_if ();
    nasti_stream_channel #(.N_CHAN(1), .DATA_WIDTH(DW), .ID_WIDTH(IW), .DEST_WIDTH(1), .USER_WIDTH(1)) dn_if ();

    nasti_stream_mux #(.N_PORT(N)) dut (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .master    (up_if.slave),
        .slave     (dn_if.master),
        .enable    (enable),
        .busy      (busy),
        .grant     (grant),
        .pkt_count (pkt_count)
    );

    always #5 aclk = ~aclk;

    beat_t       src_q [N][$];
    beat_t       exp_q [N][$];
    int          total = 0;
    int          bad   = 0;
    int          gap_pct   = 0;
    int          ready_pct = 100;
    bit          ready_manual = 1'b0;
    bit          rand_enable  = 1'b0;
    logic [N-1:0] lane_fire = '0;
    int          m_owner = -1;
    int          m_rr    = 0;
    logic [15:0] m_count = 16'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        total++;
        if (act !== exp_v) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp_v, $time);
        end
    endtask

    task automatic push_pkt(input int lane, input int len, input bit ramp, input logic [DW-1:0] base);
        beat_t b;
        for (int k = 0; k < len; k++) begin
            b.data = ramp ? (base + DW'(k)) : DW'($urandom);
            b.strb = 1'($urandom);
            b.keep = 1'($urandom);
            b.last = (k == len - 1);
            b.id   = IW'(lane);
            b.dest = 1'($urandom);
            b.user = 1'($urandom);
            src_q[lane].push_back(b);
            exp_q[lane].push_back(b);
        end
    endtask

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    task automatic wait_busy(input logic lvl, input string name);
        for (int n = 0; n < 200; n++) begin
            @(negedge aclk);
            if (busy === lvl) break;
        end
        chk(name, 32'(busy), 32'(lvl));
    endtask

    // Lane sources: hold each beat until accepted, optional gaps between beats.
    initial begin
        bit    hold;
        beat_t b;
        up_if.t_valid = '0;
        up_if.t_data  = '0;
        up_if.t_strb  = '0;
        up_if.t_keep  = '0;
        up_if.t_last  = '0;
        up_if.t_id    = '0;
        up_if.t_dest  = '0;
        up_if.t_user  = '0;
        dn_if.t_ready = '0;
        forever begin
            step();
            for (int i = 0; i < N; i++) begin
                if (lane_fire[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
                hold = up_if.t_valid[i] && !lane_fire[i];
                if (!hold)
                    up_if.t_valid[i] = (src_q[i].size() > 0) && (int'($urandom_range(99)) >= gap_pct);
                if (src_q[i].size() > 0) begin
                    b = src_q[i][0];
                    up_if.t_data[i] = b.data;
                    up_if.t_strb[i] = b.strb;
                    up_if.t_keep[i] = b.keep;
                    up_if.t_last[i] = b.last;
                    up_if.t_id[i]   = b.id;
                    up_if.t_dest[i] = b.dest;
                    up_if.t_user[i] = b.user;
                end
            end
            lane_fire = '0;
            if (!ready_manual) dn_if.t_ready[0] = (int'($urandom_range(99)) < ready_pct);
            if (rand_enable)   enable = (int'($urandom_range(99)) < 90);
        end
    end

    // Monitor: packet-level round-robin model plus scoreboard pop on each output beat.
    initial begin
        beat_t        a;
        beat_t        e;
        logic [N-1:0] exp_rdy;
        bit           exp_busy;
        bit           exp_valid;
        bit           fire;
        int           o;
        int           pick;
        int           idx;
        forever begin
            @(negedge aclk);
            if (!aresetn) begin
                chk("rst_busy", 32'(busy), 32'd0);
                chk("rst_out_valid", 32'(dn_if.t_valid[0]), 32'd0);
                chk("rst_lane_ready", 32'(up_if.t_ready), 32'd0);
                chk("rst_pkt_count", 32'(pkt_count), 32'd0);
                m_owner   = -1;
                m_rr      = 0;
                m_count   = 16'd0;
                lane_fire = '0;
            end else begin
                exp_busy  = (m_owner >= 0);
                o         = exp_busy ? m_owner : 0;
                exp_valid = exp_busy && up_if.t_valid[o];
                exp_rdy   = '0;
                if (exp_busy) exp_rdy[o] = dn_if.t_ready[0];
                chk("busy", 32'(busy), 32'(exp_busy));
                chk("grant", 32'(grant), 32'(o));
                chk("out_valid", 32'(dn_if.t_valid[0]), 32'(exp_valid));
                chk("lane_ready", 32'(up_if.t_ready), 32'(exp_rdy));
                chk("pkt_count", 32'(pkt_count), 32'(m_count));
                if (dn_if.t_valid[0] === 1'b1 && dn_if.t_ready[0] === 1'b1) begin
                    a.data = dn_if.t_data[0];
                    a.strb = dn_if.t_strb[0];
                    a.keep = dn_if.t_keep[0];
                    a.last = dn_if.t_last[0];
                    a.id   = dn_if.t_id[0];
                    a.dest = dn_if.t_dest[0];
                    a.user = dn_if.t_user[0];
                    if (exp_q[o].size() == 0) begin
                        chk("beat_expected_pending", 32'(exp_q[o].size()), 32'd1);
                    end else begin
                        e = exp_q[o].pop_front();
                        chk("beat", 32'(a), 32'(e));
                    end
                end
                fire = exp_valid && dn_if.t_ready[0];
                if (fire) lane_fire[o] = 1'b1;
                if (!exp_busy) begin
                    if (enable) begin
                        pick = -1;
                        for (int k = 0; k < N; k++) begin
                            idx = (m_rr + k) % N;
                            if (pick < 0 && up_if.t_valid[idx]) pick = idx;
                        end
                        m_owner = pick;
                    end
                end else if (fire && up_if.t_last[o]) begin
                    m_count = m_count + 16'd1;
                    m_rr    = (o + 1) % N;
                    m_owner = -1;
                end
            end
        end
    end

    initial begin
        logic [5:0] pat;
        int         nb;
        int         pending;
        pat = 6'b111001;

        // Reset with all lanes requesting, then continuous 3-beat round robin.
        for (int i = 0; i < N; i++) push_pkt(i, 3, 1'b1, DW'(8'h10 * i));
        push_pkt(0, 3, 1'b1, 8'h80);
        enable = 1'b1;
        repeat (3) step();
        #1 aresetn = 1'b1;
        @(negedge aclk);
        chk("first_cycle_idle", 32'(busy), 32'd0);
        for (int c = 1; c <= 20; c++) begin
            @(negedge aclk);
            if (c % 4 == 1) begin
                chk("rr_busy", 32'(busy), 32'd1);
                chk("rr_grant", 32'(grant), 32'(((c - 1) / 4) % 4));
            end
            if (c % 4 == 0) chk("rr_gap_idle", 32'(busy), 32'd0);
        end
        chk("rr_pkt_count", 32'(pkt_count), 32'd5);

        // Skip idle lanes: move pointer to 2, then lanes 1 and 3 compete.
        step();
        push_pkt(1, 1, 1'b0, 8'h00);
        wait_busy(1'b1, "skip_pre_busy");
        wait_busy(1'b0, "skip_pre_idle");
        step();
        enable = 1'b0;
        push_pkt(1, 2, 1'b0, 8'h00);
        push_pkt(3, 2, 1'b0, 8'h00);
        repeat (3) step();
        enable = 1'b1;
        wait_busy(1'b1, "skip_first_busy");
        chk("skip_first_grant", 32'(grant), 32'd3);
        wait_busy(1'b0, "skip_first_idle");
        wait_busy(1'b1, "skip_second_busy");
        chk("skip_second_grant", 32'(grant), 32'd1);
        wait_busy(1'b0, "skip_second_idle");

        // Backpressure on a 4-beat packet from lane 2.
        step();
        enable = 1'b0;
        ready_manual = 1'b1;
        dn_if.t_ready[0] = 1'b1;
        push_pkt(2, 4, 1'b1, 8'hA0);
        step();
        enable = 1'b1;
        wait_busy(1'b1, "bp_start");
        nb = 1;
        for (int k = 1; k < 20; k++) begin
            step();
            dn_if.t_ready[0] = (k < 6) ? pat[k] : 1'b1;
            @(negedge aclk);
            if (!busy) break;
            nb++;
        end
        chk("bp_busy_cycles", 32'(nb), 32'd6);
        ready_manual = 1'b0;

        // Enable dropped mid-packet.
        step();
        push_pkt(1, 5, 1'b0, 8'h00);
        wait_busy(1'b1, "en_start");
        chk("en_grant", 32'(grant), 32'd1);
        step();
        enable = 1'b0;
        push_pkt(3, 2, 1'b0, 8'h00);
        wait_busy(1'b0, "en_packet_end");
        for (int k = 0; k < 5; k++) begin
            @(negedge aclk);
            chk("en_hold_idle", 32'(busy), 32'd0);
        end
        step();
        enable = 1'b1;
        wait_busy(1'b1, "en_regrant");
        chk("en_regrant_lane", 32'(grant), 32'd3);
        wait_busy(1'b0, "en_regrant_done");

        // Reset pulse mid-packet.
        step();
        push_pkt(0, 6, 1'b1, 8'h50);
        wait_busy(1'b1, "rst_mid_start");
        step();
        step();
        #1 aresetn = 1'b0;
        #1;
        chk("rst_mid_busy", 32'(busy), 32'd0);
        chk("rst_mid_out_valid", 32'(dn_if.t_valid[0]), 32'd0);
        step();
        step();
        #1 aresetn = 1'b1;
        wait_busy(1'b1, "rst_mid_regrant");
        wait_busy(1'b0, "rst_mid_done");

        // Counter wrap from a preloaded count.
        step();
        force dut.pkt_count_q = 16'hFFFD;
        m_count = 16'hFFFD;
        step();
        release dut.pkt_count_q;
        for (int k = 0; k < 3; k++) push_pkt(2, 1, 1'b0, 8'h00);
        repeat (14) @(negedge aclk);
        chk("wrap_pkt_count", 32'(pkt_count), 32'd0);

        // Randomized traffic.
        gap_pct     = 30;
        ready_pct   = 70;
        rand_enable = 1'b1;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            step();
            for (int i = 0; i < N; i++)
                if (src_q[i].size() < 6 && $urandom_range(7) == 0)
                    push_pkt(i, 1 + int'($urandom_range(4)), 1'b0, 8'h00);
        end
        rand_enable = 1'b0;
        enable      = 1'b1;
        ready_pct   = 100;
        pending     = 0;
        for (int cyc = 0; cyc < 1000; cyc++) begin
            step();
            pending = 0;
            for (int i = 0; i < N; i++) pending += exp_q[i].size();
            if (pending == 0) break;
        end
        chk("drain_pending_beats", 32'(pending), 32'd0);
        wait_busy(1'b0, "final_idle");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
